// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared FSM state type and default timing for the multi-channel
//               debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    // Per-channel debounce FSM states; WAIT states qualify a pending edge
    typedef enum logic [1:0] {
        ST_DB_LOW       = 2'd0,
        ST_DB_WAIT_HIGH = 2'd1,
        ST_DB_HIGH      = 2'd2,
        ST_DB_WAIT_LOW  = 2'd3
    } estado_db_multi_t;

    // Default stability window: one second at 50 MHz
    localparam int c_time_debounce_default = 50_000_000;

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One debounce lane: 2-flop synchronizer, four-state FSM and
//               stability counter with registered level/edge outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int TIME_DEBOUNCE = c_time_debounce_default,
    parameter int CNT_WIDTH     = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_signal,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_rise_set
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(TIME_DEBOUNCE - 1);

    logic [1:0]           r_sync;
    logic                 w_s;
    estado_db_multi_t     r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_level;
    logic                 r_rise;
    logic                 r_fall;
    logic                 w_cnt_done;

    assign w_s        = r_sync[1];
    assign w_cnt_done = (r_cnt == c_cnt_last);

    // Bring the asynchronous input into the clock domain
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_signal};
        end
    end

    // Debounce FSM: a WAIT state must see a stable input for the full window
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_DB_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                ST_DB_LOW: begin
                    if (w_s) begin
                        r_state <= ST_DB_WAIT_HIGH;
                        r_cnt   <= '0;
                    end
                end
                ST_DB_WAIT_HIGH: begin
                    if (!w_s) begin
                        r_state <= ST_DB_LOW;
                        r_cnt   <= '0;
                    end else if (w_cnt_done) begin
                        r_state <= ST_DB_HIGH;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DB_HIGH: begin
                    if (!w_s) begin
                        r_state <= ST_DB_WAIT_LOW;
                        r_cnt   <= '0;
                    end
                end
                ST_DB_WAIT_LOW: begin
                    if (w_s) begin
                        r_state <= ST_DB_HIGH;
                        r_cnt   <= '0;
                    end else if (w_cnt_done) begin
                        r_state <= ST_DB_LOW;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_DB_LOW;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    // Strobe true on the edge that accepts a rise, so the top can register
    // its toggle state in the same cycle as o_rise
    assign o_rise_set = (r_state == ST_DB_WAIT_HIGH) && w_s && w_cnt_done;

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : debounce_multi
// Description : N_CH independent debounce lanes with optional toggle-on-press
//               output mode.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int TIME_DEBOUNCE = c_time_debounce_default,
    parameter int CNT_WIDTH     = 32,
    parameter int TOGGLE_MODE   = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] signal_i,
    output logic [N_CH-1:0] signal_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o
);

    logic [N_CH-1:0] w_level;
    logic [N_CH-1:0] w_rise_set;
    logic [N_CH-1:0] r_toggle;

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            debounce_channel #(
                .TIME_DEBOUNCE (TIME_DEBOUNCE),
                .CNT_WIDTH     (CNT_WIDTH)
            ) u_channel (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .i_signal   (signal_i[g]),
                .o_level    (w_level[g]),
                .o_rise     (rise_o[g]),
                .o_fall     (fall_o[g]),
                .o_rise_set (w_rise_set[g])
            );
        end
    endgenerate

    // Toggle state flips on every accepted press; releases are ignored
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_toggle <= '0;
        end else begin
            r_toggle <= r_toggle ^ w_rise_set;
        end
    end

    assign signal_o = (TOGGLE_MODE != 0) ? r_toggle : w_level;

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_multi
// Description : Directed self-checking bench for debounce_multi (level and
//               toggle instances, N_CH=2, TIME_DEBOUNCE=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_multi;

    localparam int c_n_ch = 2;
    localparam int c_time = 4;

    logic              r_clk = 1'b0;
    logic              r_rst = 1'b0;
    logic [c_n_ch-1:0] r_sig_a = '0;
    logic [c_n_ch-1:0] r_sig_b = '0;
    logic [c_n_ch-1:0] w_sig_a, w_rise_a, w_fall_a;
    logic [c_n_ch-1:0] w_sig_b, w_rise_b, w_fall_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 r_clk = ~r_clk;

    debounce_multi #(
        .N_CH(c_n_ch), .TIME_DEBOUNCE(c_time), .CNT_WIDTH(3), .TOGGLE_MODE(0)
    ) u_dut_level (
        .clk_i(r_clk), .rst_i(r_rst), .signal_i(r_sig_a),
        .signal_o(w_sig_a), .rise_o(w_rise_a), .fall_o(w_fall_a)
    );

    debounce_multi #(
        .N_CH(c_n_ch), .TIME_DEBOUNCE(c_time), .CNT_WIDTH(3), .TOGGLE_MODE(1)
    ) u_dut_toggle (
        .clk_i(r_clk), .rst_i(r_rst), .signal_i(r_sig_b),
        .signal_o(w_sig_b), .rise_o(w_rise_b), .fall_o(w_fall_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    logic [c_n_ch-1:0] v_tog;

    initial begin
        // Reset with inputs high: everything must stay zero
        r_rst   = 1'b0;
        r_sig_a = 2'b11;
        r_sig_b = 2'b11;
        for (int i = 0; i < 3; i++) tick();
        check("rst_sig_a",  w_sig_a,  0);
        check("rst_rise_a", w_rise_a, 0);
        check("rst_fall_a", w_fall_a, 0);
        check("rst_sig_b",  w_sig_b,  0);
        r_sig_a = 2'b00;
        r_sig_b = 2'b00;
        r_rst   = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Clean step on ch0: accepted after edge 7
        r_sig_a = 2'b01;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("step_rise_%0d", i), w_rise_a, (i == 7) ? 2'b01 : 2'b00);
            check($sformatf("step_sig_%0d", i),  w_sig_a,  (i >= 7) ? 2'b01 : 2'b00);
        end

        // Release ch0: fall pulse after edge 7
        r_sig_a = 2'b00;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("rel_fall_%0d", i), w_fall_a, (i == 7) ? 2'b01 : 2'b00);
            check($sformatf("rel_sig_%0d", i),  w_sig_a,  (i >= 7) ? 2'b00 : 2'b01);
        end

        // Short 3-cycle pulse on ch0 is rejected
        r_sig_a = 2'b01;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 3) r_sig_a = 2'b00;
            check($sformatf("short_rise_%0d", i), w_rise_a, 0);
            check($sformatf("short_sig_%0d", i),  w_sig_a,  0);
        end

        // Bounce 1,0,1,0,1 then hold on ch1: single rise after edge 11
        r_sig_a = 2'b10;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 1 || i == 3) r_sig_a = 2'b00;
            if (i == 2 || i == 4) r_sig_a = 2'b10;
            check($sformatf("bounce_rise_%0d", i), w_rise_a, (i == 11) ? 2'b10 : 2'b00);
            check($sformatf("bounce_sig_%0d", i),  w_sig_a,  (i >= 11) ? 2'b10 : 2'b00);
        end
        r_sig_a = 2'b00;
        for (int i = 0; i < 10; i++) tick();
        check("bounce_clear_sig", w_sig_a, 0);

        // Both channels step together: handled in the same cycle
        r_sig_a = 2'b11;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("both_rise_%0d", i), w_rise_a, (i == 7) ? 2'b11 : 2'b00);
        end
        check("both_sig", w_sig_a, 2'b11);
        r_sig_a = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("both_fall_%0d", i), w_fall_a, (i == 7) ? 2'b11 : 2'b00);
        end
        check("both_sig_low", w_sig_a, 2'b00);

        // Reset mid-wait (counter at 2) aborts; a still-high input restarts
        r_sig_a = 2'b01;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("abort_pre_rise_%0d", i), w_rise_a, 0);
        end
        r_rst = 1'b0;
        tick();
        check("abort_rst_rise", w_rise_a, 0);
        check("abort_rst_sig",  w_sig_a,  0);
        check("abort_rst_fall", w_fall_a, 0);
        r_rst = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("abort_rise_%0d", i), w_rise_a, (i == 7) ? 2'b01 : 2'b00);
            check($sformatf("abort_sig_%0d", i),  w_sig_a,  (i >= 7) ? 2'b01 : 2'b00);
        end
        r_sig_a = 2'b00;
        for (int i = 0; i < 10; i++) tick();

        // Toggle mode: three press/release cycles give 1,0,1 on ch0
        v_tog = 2'b00;
        for (int p = 0; p < 3; p++) begin
            r_sig_b = 2'b01;
            for (int i = 1; i <= 10; i++) begin
                tick();
                check($sformatf("tog_rise_%0d_%0d", p, i), w_rise_b, (i == 7) ? 2'b01 : 2'b00);
                check($sformatf("tog_sig_%0d_%0d", p, i),  w_sig_b,  (i >= 7) ? (v_tog ^ 2'b01) : v_tog);
            end
            v_tog = v_tog ^ 2'b01;
            r_sig_b = 2'b00;
            for (int i = 1; i <= 10; i++) begin
                tick();
                check($sformatf("tog_fall_%0d_%0d", p, i),   w_fall_b, (i == 7) ? 2'b01 : 2'b00);
                check($sformatf("tog_hold_%0d_%0d", p, i),   w_sig_b,  v_tog);
            end
        end
        check("tog_final", w_sig_b, 2'b01);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 Parameter N_CH, default 4, number of independent input channels (1..32).
REQ-002 Parameter TIME_DEBOUNCE, default 50_000_000, clock cycles an input must remain stable before acceptance (>= 1).
REQ-003 Parameter CNT_WIDTH, default 32, counter width; must satisfy 2**CNT_WIDTH > TIME_DEBOUNCE.
REQ-004 Parameter TOGGLE_MODE, default 0; 0 = level output, 1 = output toggles on each accepted rising edge.
REQ-005 clk_i  input  1  system clock, all logic on rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-low.
REQ-007 signal_i  input  N_CH  raw asynchronous inputs (buttons/switches).
REQ-008 signal_o  output  N_CH  debounced level (or toggle state when TOGGLE_MODE=1), registered.
REQ-009 rise_o  output  N_CH  one-cycle pulse per accepted 0->1 transition, registered.
REQ-010 fall_o  output  N_CH  one-cycle pulse per accepted 1->0 transition, registered.

Function
REQ-011 Each channel SHALL pass signal_i[n] through a 2-flop synchronizer; its output is s[n].
REQ-012 Each channel SHALL run an independent FSM: ST_DB_LOW, ST_DB_WAIT_HIGH, ST_DB_HIGH, ST_DB_WAIT_LOW.
REQ-013 ST_DB_LOW: s=1 -> ST_DB_WAIT_HIGH, counter cleared to 0; else stay.
REQ-014 ST_DB_HIGH: s=0 -> ST_DB_WAIT_LOW, counter cleared to 0; else stay.
REQ-015 ST_DB_WAIT_HIGH: s=0 -> ST_DB_LOW, counter cleared, no pulse; s=1 and counter=TIME_DEBOUNCE-1 -> ST_DB_HIGH; else counter+1.
REQ-016 ST_DB_WAIT_LOW: mirror of REQ-015 with polarities swapped, terminal state ST_DB_HIGH -> ST_DB_LOW.
REQ-017 A WAIT state SHALL last exactly TIME_DEBOUNCE cycles on a clean input; any glitch shorter than that SHALL produce no output change.
REQ-018 Latency: with a clean step on signal_i sampled at edge 1, rise_o/fall_o assert and the debounced level changes after edge TIME_DEBOUNCE+3.
REQ-019 rise_o[n] SHALL be 1 for exactly the cycle after the ST_DB_WAIT_HIGH->ST_DB_HIGH transition; fall_o[n] likewise for ST_DB_WAIT_LOW->ST_DB_LOW.
REQ-020 TOGGLE_MODE=0: signal_o[n]=1 iff state is ST_DB_HIGH or ST_DB_WAIT_LOW.
REQ-021 TOGGLE_MODE=1: signal_o[n] SHALL invert in the same cycle rise_o[n] asserts, and be unaffected by fall events.
REQ-022 Counter SHALL never exceed TIME_DEBOUNCE-1 and never wrap.
REQ-023 Channels SHALL be fully independent; simultaneous events on all channels SHALL be handled in the same cycle.

Reset
REQ-024 When rst_i=0 at a clock edge: synchronizers 0, all FSMs ST_DB_LOW, counters 0, signal_o/rise_o/fall_o 0.
REQ-025 Reset asserted mid-WAIT SHALL abort the wait with no pulse; after release, a still-high input restarts a full TIME_DEBOUNCE wait.
REQ-026 Reset SHALL take priority over every other condition.

Structure
REQ-027 Package debounce_pkg SHALL hold the FSM typedef (estado_db_multi_t) and the default timing constant.
REQ-028 The per-channel synchronizer+FSM+counter SHALL be one sub-module debounce_channel, instantiated N_CH times via generate; the top adds only TOGGLE_MODE logic and output packing.

Verification (N_CH=2, TIME_DEBOUNCE=4, unless noted)
REQ-029 Clean step 0->1 on ch0 -> rise_o[0] pulses one cycle and signal_o[0]=1 after edge 7; ch1 stays 0.
REQ-030 ch0 high for 3 cycles then low -> no rise_o, signal_o[0] stays 0.
REQ-031 Bounce 1,0,1,0,1 then held high on ch1 -> exactly one rise_o[1], 4 cycles after the final stable 1 reaches s.
REQ-032 Held high then released -> fall_o[0] single pulse, signal_o[0]=0 after edge 7 from the release.
REQ-033 rst_i=0 during WAIT_HIGH at counter=2 -> no pulse, all outputs 0; input still high after release -> rise after full 4-cycle wait.
REQ-034 TOGGLE_MODE=1, three clean press/release cycles -> signal_o[0] sequence 1,0,1; fall_o still pulses on each release.
